// File: rtl/quant_share_ctrl.sv
// quant_share_ctrl: round-robin time-sharing of one fixed-latency 16->8 quantizer among N_REQ
// lanes, with lane-tag re-association and a credit-protected output FIFO. Optional: QSHARE_STATS_EN.
module quant_share_ctrl #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned QLAT       = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [16*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  q_in_valid,
  output logic [15:0]           q_in_data,
  input  logic                  q_out_valid,
  input  logic [7:0]            q_out_data,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  output logic [ID_W-1:0]       out_id,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  tag_err
`ifdef QSHARE_STATS_EN
  ,
  output logic [31:0]           stat_issue,
  output logic [31:0]           stat_stall,
  input  logic                  stat_clr
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned QC_W  = $clog2(QLAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ID_W-1:0] r_rr_ptr;
  tag_t            r_tag [QLAT];
  logic [CNT_W-1:0] r_inflight;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [7:0]       r_mem_data [FIFO_DEPTH];
  logic [ID_W-1:0]  r_mem_id   [FIFO_DEPTH];
  logic             r_tag_err;
  logic [QC_W-1:0]  r_qign;

  logic             w_found_hi;
  logic             w_found_lo;
  logic [ID_W-1:0]  w_win_hi;
  logic [ID_W-1:0]  w_win_lo;
  logic             w_found;
  logic [ID_W-1:0]  w_winner;
  logic [CNT_W:0]   w_used;
  logic             w_credit_ok;
  logic             w_busy;
  logic             w_issue;
  tag_t             w_head;
  logic             w_qv;
  logic             w_push;
  logic             w_pop;
  logic             w_err_ev;

  // Credit covers both buffered and in-flight words so the quantizer can never overrun the FIFO.
  assign w_used      = (CNT_W+1)'(r_count) + (CNT_W+1)'(r_inflight);
  assign w_credit_ok = w_used < (CNT_W+1)'(FIFO_DEPTH);
  assign w_busy      = (r_inflight != '0) | (r_count != '0);

  // Round-robin: first valid lane above rr_ptr, else wrap to the lowest valid lane.
  always_comb begin : winner_search
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_win_hi   = '0;
    w_win_lo   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (req_valid[i] && !w_found_hi && (ID_W'(i) > r_rr_ptr)) begin
        w_found_hi = 1'b1;
        w_win_hi   = ID_W'(i);
      end
      if (req_valid[i] && !w_found_lo) begin
        w_found_lo = 1'b1;
        w_win_lo   = ID_W'(i);
      end
    end
  end

  assign w_found  = w_found_hi | w_found_lo;
  assign w_winner = w_found_hi ? w_win_hi : w_win_lo;
  assign w_issue  = rst_n & (r_state == S_RUN) & w_credit_ok & w_found;

  always_ff @(posedge clk) begin : state_reg
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin : fsm_next
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_state_nxt = S_RUN;
      S_RUN:   if (!enable) w_state_nxt = w_busy ? S_DRAIN : S_IDLE;
      S_DRAIN: begin
        if (enable)       w_state_nxt = S_RUN;
        else if (!w_busy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant and quantizer drive are combinational in the issue cycle.
  always_comb begin : fsm_out
    req_ready  = '0;
    q_in_valid = 1'b0;
    q_in_data  = '0;
    if (w_issue) begin
      q_in_valid = 1'b1;
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (ID_W'(i) == w_winner) begin
          req_ready[i] = 1'b1;
          q_in_data    = req_data[16*i +: 16];
        end
      end
    end
  end

  always_ff @(posedge clk) begin : rr_reg
    if (!rst_n)       r_rr_ptr <= ID_W'(N_REQ - 1);
    else if (w_issue) r_rr_ptr <= w_winner;
  end

  // Lane tags travel alongside the quantizer so results can be re-associated.
  always_ff @(posedge clk) begin : tag_pipe
    if (!rst_n) begin
      for (int i = 0; i < int'(QLAT); i++) r_tag[i] <= '0;
    end else begin
      if (w_issue) begin
        r_tag[0].vld <= 1'b1;
        r_tag[0].id  <= w_winner;
      end else begin
        r_tag[0] <= '0;
      end
      for (int i = 1; i < int'(QLAT); i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign w_head   = r_tag[QLAT-1];
  assign w_qv     = q_out_valid & (r_qign == '0);
  assign w_push   = w_head.vld & w_qv;
  assign w_err_ev = w_head.vld ^ w_qv;
  assign w_pop    = out_valid & out_ready;

  // Quantizer results from words issued before a reset are masked for QLAT cycles.
  always_ff @(posedge clk) begin : qign_reg
    if (!rst_n)              r_qign <= QC_W'(QLAT);
    else if (r_qign != '0)   r_qign <= r_qign - QC_W'(1);
  end

  always_ff @(posedge clk) begin : inflight_reg
    if (!rst_n) begin
      r_inflight <= '0;
    end else begin
      case ({w_issue, w_head.vld})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clk) begin : tag_err_reg
    if (!rst_n)        r_tag_err <= 1'b0;
    else if (w_err_ev) r_tag_err <= 1'b1;
  end

  always_ff @(posedge clk) begin : fifo_ctrl
    if (!rst_n) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin : fifo_mem
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= q_out_data;
      r_mem_id[r_wr_ptr]   <= w_head.id;
    end
  end

  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem_data[r_rd_ptr] : '0;
  assign out_id    = out_valid ? r_mem_id[r_rd_ptr]   : '0;
  assign busy      = w_busy;
  assign tag_err   = r_tag_err;

`ifdef QSHARE_STATS_EN
  logic w_stall;
  assign w_stall = (r_state == S_RUN) & (|req_valid) & ~w_credit_ok;

  // Wrapping event counters; clear wins over increment.
  always_ff @(posedge clk) begin : stats_reg
    if (!rst_n || stat_clr) begin
      stat_issue <= '0;
      stat_stall <= '0;
    end else begin
      if (w_issue) stat_issue <= stat_issue + 32'd1;
      if (w_stall) stat_stall <= stat_stall + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_quant_share_ctrl.sv
// tb_quant_share_ctrl: randomized + directed bench with a transaction-level reference model,
// a fixed-latency quantizer model, and a scoreboard-driven output monitor.
module tb_quant_share_ctrl;
  localparam int N_REQ      = 4;
  localparam int ID_W       = 2;
  localparam int QLAT       = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                enable;
  logic [N_REQ-1:0]    req_valid;
  logic [16*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                q_in_valid;
  logic [15:0]         q_in_data;
  logic                q_out_valid;
  logic [7:0]          q_out_data;
  logic                out_valid;
  logic [7:0]          out_data;
  logic [ID_W-1:0]     out_id;
  logic                out_ready;
  logic                busy;
  logic                tag_err;
  logic                inject;

  always #5 clk = ~clk;

  quant_share_ctrl #(.N_REQ(N_REQ), .ID_W(ID_W), .QLAT(QLAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .q_in_valid(q_in_valid), .q_in_data(q_in_data),
    .q_out_valid(q_out_valid), .q_out_data(q_out_data),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_ready(out_ready),
    .busy(busy), .tag_err(tag_err)
  );

  // Quantizer: signed right shift by fractional_length=7, saturating to int8.
  function automatic logic [7:0] quant(input logic [15:0] d);
    int v;
    v = int'($signed(d));
    v = v >>> 7;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return 8'(v);
  endfunction

  // External quantizer model: free-running, not reset, fixed latency QLAT.
  logic [QLAT-1:0] qp_v = '0;
  logic [7:0]      qp_d [QLAT];
  always @(posedge clk) begin
    qp_v[0] <= q_in_valid;
    qp_d[0] <= quant(q_in_data);
    for (int i = 1; i < QLAT; i++) begin
      qp_v[i] <= qp_v[i-1];
      qp_d[i] <= qp_d[i-1];
    end
  end
  assign q_out_valid = qp_v[QLAT-1] | inject;
  assign q_out_data  = qp_d[QLAT-1];

  typedef struct {
    int         id;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  int   iss_q[$];
  int   m_mode;
  int   m_rr;
  bit   m_err;
  bit   first_after_rst;
  int   cyc;
  int   checks;
  int   errors;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: outstanding words are tracked by issue cycle; a word is visible at the
  // output QLAT+1 cycles after issue once everything older has been accepted.
  task automatic model_step();
    int   winner;
    bit   busy_e;
    bit   ov_e;
    logic [N_REQ-1:0] rr_e;
    winner = -1;
    busy_e = (iss_q.size() != 0);
    ov_e   = (iss_q.size() > 0) && (iss_q[0] + QLAT + 1 <= cyc);
    if (!rst_n) begin
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_q_in_valid", 32'(q_in_valid), 32'd0);
      iss_q.delete();
      sb.delete();
      m_mode = M_IDLE;
      m_rr = N_REQ - 1;
      m_err = 1'b0;
      first_after_rst = 1'b1;
    end else begin
      if (m_mode == M_RUN && iss_q.size() < FIFO_DEPTH && req_valid != '0) begin
        for (int k = 1; k <= N_REQ; k++) begin
          int l;
          l = (m_rr + k) % N_REQ;
          if (winner < 0 && req_valid[l]) winner = l;
        end
      end
      rr_e = '0;
      if (winner >= 0) rr_e[winner] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(rr_e));
      chk("q_in_valid", 32'(q_in_valid), 32'(winner >= 0));
      if (winner >= 0) chk("q_in_data", 32'(q_in_data), 32'(req_data[16*winner +: 16]));
      chk("out_valid", 32'(out_valid), 32'(ov_e));
      chk("busy", 32'(busy), 32'(busy_e));
      chk("tag_err", 32'(tag_err), 32'(m_err));
      if (first_after_rst) begin
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        first_after_rst = 1'b0;
      end
      if (ov_e && out_ready) void'(iss_q.pop_front());
      if (winner >= 0) begin
        exp_t e;
        e.id = winner;
        e.d  = quant(req_data[16*winner +: 16]);
        iss_q.push_back(cyc);
        sb.push_back(e);
        m_rr = winner;
      end
      case (m_mode)
        M_IDLE:  if (enable) m_mode = M_RUN;
        M_RUN:   if (!enable) m_mode = busy_e ? M_DRAIN : M_IDLE;
        default: begin
          if (enable)       m_mode = M_RUN;
          else if (!busy_e) m_mode = M_IDLE;
        end
      endcase
      if (inject) m_err = 1'b1;
    end
    cyc++;
  endtask

  // Monitor: compares each accepted output word against the scoreboard head.
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_id", 32'(out_id), 32'(e.id));
        chk("out_data", 32'(out_data), 32'(e.d));
      end
    end
  end

  function automatic logic [16*N_REQ-1:0] rnd_data();
    logic [16*N_REQ-1:0] d;
    for (int i = 0; i < N_REQ; i++) d[16*i +: 16] = 16'($urandom);
    return d;
  endfunction

  task automatic tick(input logic en, input logic [N_REQ-1:0] rv, input logic ro,
                      input logic rs, input logic inj, input logic [16*N_REQ-1:0] d);
    @(negedge clk);
    enable    = en;
    req_valid = rv;
    out_ready = ro;
    rst_n     = rs;
    inject    = inj;
    req_data  = d;
    #1;
    model_step();
  endtask

  initial begin
    logic [16*N_REQ-1:0] d;
    checks = 0; errors = 0; cyc = 0;
    m_mode = M_IDLE; m_rr = N_REQ - 1; m_err = 1'b0; first_after_rst = 1'b0;
    rst_n = 1'b0; enable = 1'b0; req_valid = '0; out_ready = 1'b0; inject = 1'b0; req_data = '0;
    repeat (2) tick(1'b0, '0, 1'b0, 1'b0, 1'b0, rnd_data());

    // Lane 2 alone, word 0x0100 -> 0x02 with id 2.
    d = rnd_data();
    d[16*2 +: 16] = 16'h0100;
    tick(1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, d);
    tick(1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, d);
    repeat (6) tick(1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, rnd_data());

    // All lanes, sink always ready: rotating grants at one per cycle.
    repeat (40) tick(1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, rnd_data());

    // Backpressure: credit caps issues at FIFO_DEPTH, then one issue per pop.
    repeat (12) tick(1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, rnd_data());
    repeat (10) tick(1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, rnd_data());

    // Random traffic.
    repeat (1500)
      tick(($urandom_range(0, 9) != 0), N_REQ'($urandom), ($urandom_range(0, 3) != 0),
           1'b1, 1'b0, rnd_data());

    // Drain, then issue 3 words and drop enable.
    repeat (20) tick(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, rnd_data());
    tick(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, rnd_data());
    repeat (3) tick(1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, rnd_data());
    repeat (6) tick(1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, rnd_data());
    repeat (10) tick(1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, rnd_data());

    // Reset with one word buffered and two in flight.
    tick(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, rnd_data());
    repeat (3) tick(1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, rnd_data());
    tick(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, rnd_data());
    repeat (12) tick(1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, rnd_data());

    // Spurious quantizer output with an empty tag pipe.
    repeat (15) tick(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, rnd_data());
    chk("sb_empty", 32'(sb.size()), 32'd0);
    tick(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, rnd_data());
    repeat (6) tick(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, rnd_data());
    tick(1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, rnd_data());
    repeat (8) tick(1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, rnd_data());

    // Reset clears the sticky error.
    tick(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, rnd_data());
    repeat (6) tick(1'b1, 4'b0011, 1'b1, 1'b1, 1'b0, rnd_data());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
